// File: rtl/adaptive_freq_model.sv
// Adaptive frequency model: per-symbol counts, cumulative bounds lookup and first-seen symbol log.
// Build option AMODEL_RESCALE_EN: halve counts at MAX_TOTAL; when undefined the model freezes there.
module adaptive_freq_model #(
  parameter int SYM_W     = 8,
  parameter int PROB_W    = 16,
  parameter int LANES     = 8,
  parameter int INC       = 1,
  parameter int MAX_TOTAL = 16'hFF00
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rst_done,
  input  logic [SYM_W-1:0]  symbol_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic [PROB_W-1:0] lower_bound_out,
  output logic [PROB_W-1:0] upper_bound_out,
  output logic [PROB_W-1:0] total_out,
  output logic              valid_out,
  input  logic              read_en,
  output logic [SYM_W-1:0]  entry_out,
  output logic              entry_valid_out,
  output logic [SYM_W:0]    entry_count_out
);
  localparam int NSYM  = 2 ** SYM_W;
  localparam int NGRP  = NSYM / LANES;
  localparam int GRP_W = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam logic [PROB_W-1:0] INC_P    = PROB_W'(INC);
  localparam logic [PROB_W-1:0] MAX_P    = PROB_W'(MAX_TOTAL);
  localparam logic [GRP_W-1:0]  LAST_GRP = GRP_W'(NGRP - 1);

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_SCAN, S_EMIT, S_RESCALE} state_t;

  state_t            state_q;
  logic [GRP_W-1:0]  grp_q;
  logic [SYM_W-1:0]  sym_q;
  logic [PROB_W-1:0] cum_q;
  logic [PROB_W-1:0] total_q;
  logic [SYM_W:0]    wr_idx_q;
  logic [SYM_W:0]    rd_idx_q;
  logic [PROB_W-1:0] count_q [NSYM];
  logic [SYM_W-1:0]  log_q [NSYM];
  logic [NSYM-1:0]   logged_q;

  logic [SYM_W-1:0]  lane_idx   [LANES];
  logic [PROB_W-1:0] lane_below [LANES];
  logic [PROB_W-1:0] below_sum;
  logic [PROB_W-1:0] cnt_s;
  logic [PROB_W-1:0] total_new;
  logic              seen;
  logic              upd_en;
  logic              grp_last;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_idx[gi]   = SYM_W'(int'(grp_q) * LANES + gi);
    assign lane_below[gi] = (lane_idx[gi] < sym_q) ? count_q[lane_idx[gi]] : '0;
  end

`ifdef AMODEL_RESCALE_EN
  logic [PROB_W-1:0] lane_half [LANES];
  logic [PROB_W-1:0] half_sum;

  // (c+1)>>1 keeps every nonzero count at least 1 so the seen set never shrinks
  for (genvar gi = 0; gi < LANES; gi++) begin : g_half
    logic [PROB_W:0] inc_cnt;
    assign inc_cnt       = {1'b0, count_q[lane_idx[gi]]} + (PROB_W+1)'(1);
    assign lane_half[gi] = inc_cnt[PROB_W:1];
  end

  always_comb begin
    half_sum = '0;
    for (int l = 0; l < LANES; l++) half_sum = half_sum + lane_half[l];
  end

  assign upd_en = 1'b1;
`else
  assign upd_en = (total_new <= MAX_P);
`endif

  always_comb begin
    below_sum = '0;
    for (int l = 0; l < LANES; l++) below_sum = below_sum + lane_below[l];
  end

  assign cnt_s           = count_q[sym_q];
  assign seen            = (cnt_s != '0);
  assign total_new       = total_q + INC_P;
  assign grp_last        = (grp_q == LAST_GRP);
  assign ready_out       = (state_q == S_IDLE);
  assign entry_count_out = wr_idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_CLEAR;
      grp_q           <= '0;
      sym_q           <= '0;
      cum_q           <= '0;
      total_q         <= '0;
      wr_idx_q        <= '0;
      rst_done        <= 1'b0;
      valid_out       <= 1'b0;
      lower_bound_out <= '0;
      upper_bound_out <= '0;
      total_out       <= '0;
    end else begin
      valid_out <= 1'b0;
      case (state_q)
        S_CLEAR: begin
          grp_q <= grp_last ? '0 : grp_q + 1'b1;
          if (grp_last) begin
            state_q  <= S_IDLE;
            rst_done <= 1'b1;
          end
        end
        S_IDLE: begin
          if (valid_in) begin
            sym_q   <= symbol_in;
            cum_q   <= '0;
            grp_q   <= '0;
            state_q <= S_SCAN;
          end
        end
        S_SCAN: begin
          cum_q <= cum_q + below_sum;
          grp_q <= grp_last ? '0 : grp_q + 1'b1;
          if (grp_last) state_q <= S_EMIT;
        end
        S_EMIT: begin
          lower_bound_out <= cum_q;
          upper_bound_out <= cum_q + (seen ? cnt_s : PROB_W'(1));
          total_out       <= seen ? total_q : total_q + PROB_W'(1);
          valid_out       <= 1'b1;
          if (upd_en) total_q <= total_new;
          if (!logged_q[sym_q]) wr_idx_q <= wr_idx_q + 1'b1;
          state_q <= S_IDLE;
`ifdef AMODEL_RESCALE_EN
          if (total_new >= MAX_P) state_q <= S_RESCALE;
`endif
        end
`ifdef AMODEL_RESCALE_EN
        S_RESCALE: begin
          total_q <= ((grp_q == '0) ? '0 : total_q) + half_sum;
          grp_q   <= grp_last ? '0 : grp_q + 1'b1;
          if (grp_last) state_q <= S_IDLE;
        end
`endif
        default: state_q <= S_CLEAR;
      endcase
    end
  end

  // Table storage has no reset; the CLEAR walk zeroes it a lane group at a time.
  always_ff @(posedge clk) begin
    if (!rst) begin
      case (state_q)
        S_CLEAR: begin
          for (int l = 0; l < LANES; l++) begin
            count_q[lane_idx[l]]  <= '0;
            logged_q[lane_idx[l]] <= 1'b0;
          end
        end
        S_EMIT: begin
          if (upd_en) count_q[sym_q] <= cnt_s + INC_P;
          if (!logged_q[sym_q]) begin
            logged_q[sym_q]                 <= 1'b1;
            log_q[wr_idx_q[SYM_W-1:0]] <= sym_q;
          end
        end
`ifdef AMODEL_RESCALE_EN
        S_RESCALE: begin
          for (int l = 0; l < LANES; l++) count_q[lane_idx[l]] <= lane_half[l];
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_idx_q        <= '0;
      entry_out       <= '0;
      entry_valid_out <= 1'b0;
    end else begin
      entry_valid_out <= 1'b0;
      if (read_en && (rd_idx_q < wr_idx_q)) begin
        entry_out       <= log_q[rd_idx_q[SYM_W-1:0]];
        entry_valid_out <= 1'b1;
        rd_idx_q        <= rd_idx_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_adaptive_freq_model.sv
// Scoreboard bench for adaptive_freq_model (SYM_W=4, LANES=4, INC=1, MAX_TOTAL=16).
// Expectations branch on AMODEL_RESCALE_EN to match whichever build is compiled.
module tb_adaptive_freq_model;
  localparam int SYM_W  = 4;
  localparam int PROB_W = 16;
  localparam int LAT    = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rst_done;
  logic [SYM_W-1:0]  symbol_in = '0;
  logic              valid_in = 1'b0;
  logic              ready_out;
  logic [PROB_W-1:0] lower_bound_out;
  logic [PROB_W-1:0] upper_bound_out;
  logic [PROB_W-1:0] total_out;
  logic              valid_out;
  logic              read_en = 1'b0;
  logic [SYM_W-1:0]  entry_out;
  logic              entry_valid_out;
  logic [SYM_W:0]    entry_count_out;

  adaptive_freq_model #(
    .SYM_W(SYM_W), .PROB_W(PROB_W), .LANES(4), .INC(1), .MAX_TOTAL(16)
  ) dut (
    .clk(clk), .rst(rst), .rst_done(rst_done),
    .symbol_in(symbol_in), .valid_in(valid_in), .ready_out(ready_out),
    .lower_bound_out(lower_bound_out), .upper_bound_out(upper_bound_out),
    .total_out(total_out), .valid_out(valid_out),
    .read_en(read_en), .entry_out(entry_out), .entry_valid_out(entry_valid_out),
    .entry_count_out(entry_count_out)
  );

  always #5 clk = ~clk;

  typedef struct { int lo; int up; int tot; int cyc; } exp_t;
  exp_t exp_q[$];
  int   ent_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  exp_t mon_e;
  int   mon_ent;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL bounds_unexpected: got (%0d,%0d,%0d) at cycle %0d, none expected",
                 lower_bound_out, upper_bound_out, total_out, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (int'(lower_bound_out) != mon_e.lo || int'(upper_bound_out) != mon_e.up ||
            int'(total_out) != mon_e.tot) begin
          fails++;
          $display("FAIL bounds: got (%0d,%0d,%0d), want (%0d,%0d,%0d)",
                   lower_bound_out, upper_bound_out, total_out, mon_e.lo, mon_e.up, mon_e.tot);
        end else
          $display("[TB] emit (%0d,%0d,%0d) ok", lower_bound_out, upper_bound_out, total_out);
        tests++;
        if (cyc != mon_e.cyc) begin
          fails++;
          $display("FAIL latency: valid_out at cycle %0d, want %0d", cyc, mon_e.cyc);
        end
      end
    end
    if (entry_valid_out === 1'b1) begin
      tests++;
      if (ent_q.size() == 0) begin
        fails++;
        $display("FAIL entry_unexpected: got entry %0d, none expected", entry_out);
      end else begin
        mon_ent = ent_q.pop_front();
        if (int'(entry_out) != mon_ent) begin
          fails++;
          $display("FAIL entry: got %0d, want %0d", entry_out, mon_ent);
        end else
          $display("[TB] log entry %0d ok", entry_out);
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  task automatic do_reset();
    int n = 0;
    @(negedge clk);
    rst = 1'b1; valid_in = 1'b0; read_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_done_in_reset", int'(rst_done), 0);
    check("ready_in_reset", int'(ready_out), 0);
    check("outs_in_reset", int'(valid_out) + int'(entry_valid_out) + int'(lower_bound_out) +
          int'(upper_bound_out) + int'(total_out), 0);
    while (rst_done !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("clear_cycles", n, 4);
    check("ready_after_clear", int'(ready_out), 1);
    check("entry_count_reset", int'(entry_count_out), 0);
  endtask

  task automatic send(input int s, input bit expect_out, input int lo, input int up, input int tot);
    int n = 0;
    @(negedge clk);
    symbol_in = SYM_W'(s);
    valid_in  = 1'b1;
    while (ready_out !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (ready_out !== 1'b1) begin
      tests++; fails++;
      $display("FAIL accept_timeout: symbol %0d not accepted after %0d cycles", s, n);
      valid_in = 1'b0;
      return;
    end
    if (expect_out) exp_q.push_back('{lo, up, tot, cyc + 1 + LAT});
    @(posedge clk);
    #1 valid_in = 1'b0;
  endtask

  task automatic read_log(input int nreads);
    for (int i = 0; i < nreads; i++) begin
      @(negedge clk);
      read_en = 1'b1;
    end
    @(negedge clk);
    read_en = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || ent_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("drain_pending", exp_q.size() + ent_q.size(), 0);
  endtask

  initial begin
    int n;
    int busy_req;

    // Basic coding sequence and log readback
    do_reset();
    read_log(1);
    send(5, 1, 0, 1, 1);
    send(5, 1, 0, 1, 1);
    send(3, 1, 0, 1, 3);
    send(5, 1, 1, 3, 3);
    drain();
    check("entry_count_seq", int'(entry_count_out), 2);
    ent_q.push_back(5);
    ent_q.push_back(3);
    read_log(3);
    drain();

    // Threshold behaviour with a single repeated symbol
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      if (k == 1) send(2, 1, 0, 1, 1);
      else        send(2, 1, 0, k - 1, k - 1);
    end
    n = 0;
    while (valid_out !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (ready_out !== 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
`ifdef AMODEL_RESCALE_EN
    busy_req = 4;
`else
    busy_req = 0;
`endif
    check("busy_after_16th", n, busy_req);
`ifdef AMODEL_RESCALE_EN
    send(2, 1, 0, 8, 8);
    drain();
    check("entry_count_rescale", int'(entry_count_out), 1);
`else
    for (int k = 17; k <= 20; k++) send(2, 1, 0, 16, 16);
    send(9, 1, 16, 17, 17);
    drain();
    check("entry_count_frozen", int'(entry_count_out), 2);
    ent_q.push_back(2);
    ent_q.push_back(9);
    read_log(3);
    drain();
`endif

    // Reset while a symbol is mid-scan: no output, table cleared
    send(7, 0, 0, 0, 0);
    do_reset();
    repeat (8) @(negedge clk);
    send(7, 1, 0, 1, 1);
    drain();
    check("entry_count_after_midscan", int'(entry_count_out), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
